// File: rtl/fdiv_result_checker_if.sv
// rtl/fdiv_result_checker_if.sv - operand/golden/result stream into the fdiv2 result checker
interface fdiv_result_checker_if;
  logic        in_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] expected;
  logic [31:0] result;
  logic        finish;

  modport master (
    output in_valid, op1, op2, expected, result, finish
  );

  modport slave (
    input in_valid, op1, op2, expected, result, finish
  );
endinterface

// File: rtl/fdiv_result_checker.sv
// rtl/fdiv_result_checker.sv - delays issued vectors by the divider latency and checks fdiv2 results
// Compares with ULP tolerance plus zero/inf-nan class rules; keeps stats and the first failing vector.
module fdiv_result_checker #(
  parameter int LATENCY = 12,
  parameter int MAX_ULP = 1,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fdiv_result_checker_if.slave  stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      checked_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  err_valid,
  output logic [31:0]           err_op1,
  output logic [31:0]           err_op2,
  output logic [31:0]           err_result,
  output logic [31:0]           err_expected
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DW-1:0]     drain_cnt;
  logic [LATENCY-1:0] vld;
  logic [31:0]       d_op1 [LATENCY];
  logic [31:0]       d_op2 [LATENCY];
  logic [31:0]       d_exp [LATENCY];
  logic              accept;
  logic              cmp_fire;
  logic              cmp_ok;
  logic [31:0]       e, r;
  logic [30:0]       mag_diff;

  assign accept = stim.in_valid && (state == IDLE || state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stim.finish) state_nxt = DRAIN;
               else if (accept) state_nxt = RUN;
      RUN:     if (stim.finish) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DW'(LATENCY - 1)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts edges already spent in DRAIN; the LATENCY-th one moves to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              drain_cnt <= '0;
    else if (state != DRAIN) drain_cnt <= '0;
    else                     drain_cnt <= drain_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        d_op1[i] <= '0;
        d_op2[i] <= '0;
        d_exp[i] <= '0;
      end
    end else begin
      vld[0]   <= accept;
      d_op1[0] <= stim.op1;
      d_op2[0] <= stim.op2;
      d_exp[0] <= stim.expected;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        d_op1[i] <= d_op1[i-1];
        d_op2[i] <= d_op2[i-1];
        d_exp[i] <= d_exp[i-1];
      end
    end
  end

  assign cmp_fire = vld[LATENCY-1];
  assign e        = d_exp[LATENCY-1];
  assign r        = stim.result;
  // Magnitude bits are monotonic in value, so one unsigned distance spans exponent boundaries.
  assign mag_diff = (r[30:0] >= e[30:0]) ? (r[30:0] - e[30:0]) : (e[30:0] - r[30:0]);

  always_comb begin
    cmp_ok = 1'b0;
    if (e[30:23] == 8'd0)
      cmp_ok = (r[30:23] == 8'd0) && (r[31] == e[31]);
    else if (e[30:23] == 8'd255)
      cmp_ok = (r[30:23] == 8'd255) && (r[31] == e[31]);
    else
      cmp_ok = (r[31] == e[31]) && (mag_diff <= 31'(MAX_ULP));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checked_cnt  <= '0;
      err_cnt      <= '0;
      err_valid    <= 1'b0;
      err_op1      <= '0;
      err_op2      <= '0;
      err_result   <= '0;
      err_expected <= '0;
    end else begin
      err_valid <= cmp_fire && !cmp_ok;
      if (cmp_fire) begin
        if (checked_cnt != CNT_MAX) checked_cnt <= checked_cnt + 1'b1;
        if (!cmp_ok) begin
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) begin
            err_op1      <= d_op1[LATENCY-1];
            err_op2      <= d_op2[LATENCY-1];
            err_result   <= r;
            err_expected <= e;
          end
        end
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_fdiv_result_checker.sv
// tb/tb_fdiv_result_checker.sv - directed bench for fdiv_result_checker (LATENCY=12, MAX_ULP=1)
module tb_fdiv_result_checker;

  logic        clk;
  logic        rst_n;
  logic        busy, done, pass, err_valid;
  logic [31:0] checked_cnt, err_cnt;
  logic [31:0] err_op1, err_op2, err_result, err_expected;
  logic [31:0] rq [12];
  int          n_pass, n_total;

  fdiv_result_checker_if stim ();

  fdiv_result_checker #(.LATENCY(12), .MAX_ULP(1), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .checked_cnt  (checked_cnt),
    .err_cnt      (err_cnt),
    .err_valid    (err_valid),
    .err_op1      (err_op1),
    .err_op2      (err_op2),
    .err_result   (err_result),
    .err_expected (err_expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Drives one cycle of stimulus; result r emerges from the modelled divider 12 steps later.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input logic [31:0] r, input logic fin);
    stim.in_valid = v;
    stim.op1      = a;
    stim.op2      = b;
    stim.expected = e;
    stim.finish   = fin;
    stim.result   = rq[11];
    for (int i = 11; i > 0; i--) rq[i] = rq[i-1];
    rq[0] = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 32'h0, $urandom, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_checked"}, checked_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_err_valid"}, err_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) rq[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] r;
    int          busy_hi;
    int          fails;
    logic        stale;

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    stim.in_valid = 1'b0;
    stim.op1 = '0;
    stim.op2 = '0;
    stim.expected = '0;
    stim.result = '0;
    stim.finish = 1'b0;
    for (int i = 0; i < 12; i++) rq[i] = 32'h0;
    @(posedge clk);
    #1;

    // Reset and idle with a toggling result
    do_reset("rst");
    chk("rst_pass", pass, 0);
    chk("rst_err_op1", err_op1, 0);
    chk("rst_err_expected", err_expected, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0, 32'h0, (i % 2) ? 32'hFFFFFFFF : 32'h0, 1'b0);
    chk("idle_checked", checked_cnt, 0);
    chk("idle_err", err_cnt, 0);
    chk("idle_busy", busy, 0);

    // Exact match, finish one cycle later
    step(1'b1, 32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3FC00000, 1'b0);
    chk("exact_busy_run", busy, 1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("exact_busy_drain", busy, 1);
    for (int i = 0; i < 11; i++) idle();
    chk("exact_done_early", done, 0);
    chk("exact_checked_pre", checked_cnt, 1);
    idle();
    chk("exact_done", done, 1);
    chk("exact_pass", pass, 1);
    chk("exact_checked", checked_cnt, 1);
    chk("exact_err", err_cnt, 0);
    chk("exact_busy_off", busy, 0);
    step(1'b1, 32'h1, 32'h1, 32'h3F800000, 32'h0, 1'b1);
    for (int i = 0; i < 14; i++) idle();
    chk("done_hold", done, 1);
    chk("done_ignore_vec", checked_cnt, 1);

    // ULP tolerance and first-failure capture
    do_reset("rst2");
    step(1'b1, 32'hA, 32'hB, 32'h3FC00000, 32'h3FC00001, 1'b0);
    step(1'b1, 32'hC, 32'hD, 32'h3FFFFFFF, 32'h40000000, 1'b0);
    step(1'b1, 32'h1, 32'h2, 32'h3FC00000, 32'h3FC00002, 1'b0);
    step(1'b1, 32'h3, 32'h4, 32'h3FC00000, 32'h3FC00003, 1'b1);
    for (int j = 1; j <= 13; j++) begin
      idle();
      if (j == 9) chk("ulp_ev_quiet", err_valid, 0);
      if (j == 10) begin
        chk("ulp_checked2", checked_cnt, 2);
        chk("ulp_err0", err_cnt, 0);
      end
      if (j == 11) begin
        chk("ulp_err1", err_cnt, 1);
        chk("ulp_ev1", err_valid, 1);
        chk("cap_op1", err_op1, 32'h1);
        chk("cap_op2", err_op2, 32'h2);
        chk("cap_result", err_result, 32'h3FC00002);
        chk("cap_expected", err_expected, 32'h3FC00000);
      end
      if (j == 12) begin
        chk("ulp_err2", err_cnt, 2);
        chk("ulp_ev2", err_valid, 1);
        chk("cap_keep_op1", err_op1, 32'h1);
        chk("cap_keep_result", err_result, 32'h3FC00002);
        chk("ulp_done", done, 1);
        chk("ulp_pass", pass, 0);
      end
      if (j == 13) chk("ulp_ev_end", err_valid, 0);
    end

    // Zero and special classes
    do_reset("rst3");
    step(1'b1, 32'h0, 32'h3F800000, 32'h00000000, 32'h00000001, 1'b0);
    step(1'b1, 32'h0, 32'h40000000, 32'h00000000, 32'h80000000, 1'b0);
    step(1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7F812345, 1'b1);
    for (int i = 0; i < 12; i++) idle();
    chk("spec_done", done, 1);
    chk("spec_checked", checked_cnt, 3);
    chk("spec_err", err_cnt, 1);
    chk("spec_cap_op2", err_op2, 32'h40000000);
    chk("spec_cap_result", err_result, 32'h80000000);

    // 1000 back-to-back vectors with four planted 5-ULP errors
    do_reset("rst4");
    busy_hi = 0;
    fails = 0;
    for (int i = 0; i < 1000; i++) begin
      e = {1'($urandom), 8'($urandom_range(1, 253)), 23'($urandom)};
      if (i % 250 == 7) begin
        r = e + 32'd5;
        fails++;
      end else begin
        r = e + 32'($urandom_range(0, 1));
      end
      step(1'b1, i, ~i, e, r, i == 999);
      if (busy) busy_hi++;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      idle();
      if (busy) busy_hi++;
    end
    chk("stream_busy_cycles", busy_hi, 1000 - 1 + 12);
    chk("stream_done", done, 1);
    chk("stream_checked", checked_cnt, 1000);
    chk("stream_err", err_cnt, fails);
    chk("stream_cap_op1", err_op1, 32'd7);

    // Reset during DRAIN with vectors still in flight
    do_reset("rst5");
    for (int i = 0; i < 5; i++) step(1'b1, i, i, 32'h3FC00000, 32'h3FC00009, i == 4);
    idle();
    idle();
    chk("mid_busy", busy, 1);
    do_reset("mid");
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 32'h0, 32'h0, 32'h3FC00009, 1'b0);
      if (checked_cnt != 0 || err_valid || busy || done) stale = 1'b1;
    end
    chk("mid_no_stale", stale, 0);
    chk("mid_idle_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
